// File: rtl/mac_pipe_sat.sv
`default_nettype none
// ============================================================================
// Module   : mac_pipe_sat
// Purpose  : Streaming signed multiply-accumulate with optional product
//            pipeline stage and saturating or wrapping accumulation.
// Revision : 1.0
// ============================================================================
module mac_pipe_sat #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int PIPE      = 0,
  parameter int SAT       = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  input  logic                        valid_in,
  input  logic                        clear_acc,
  output logic                        valid_out,
  output logic signed [ACC_WIDTH-1:0] f,
  output logic                        overflow
);

  localparam int PW  = 2 * WIDTH;
  localparam int EXT = ACC_WIDTH + 1 - PW;
  localparam logic [ACC_WIDTH-1:0] C_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] C_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  generate
    if (ACC_WIDTH < 2 * WIDTH) begin : g_bad_acc_width
      $error("mac_pipe_sat: ACC_WIDTH must be >= 2*WIDTH");
    end
  endgenerate

  // Stage 0: operand capture
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             v0_q;
  logic             clr0_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      v0_q   <= 1'b0;
      clr0_q <= 1'b0;
    end else begin
      a_q    <= a;
      b_q    <= b;
      v0_q   <= valid_in;
      clr0_q <= clear_acc;
    end
  end

  // Operands are sign-extended to the product width so the low PW bits of
  // the unsigned multiply equal the signed product.
  logic [PW-1:0] w_a_ext;
  logic [PW-1:0] w_b_ext;
  logic [PW-1:0] w_prod0;

  assign w_a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign w_b_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign w_prod0 = w_a_ext * w_b_ext;

  logic [PW-1:0] w_acc_prod;
  logic          w_acc_valid;
  logic          w_acc_clr;

  generate
    if (PIPE != 0) begin : g_pipe
      logic [PW-1:0] prod_q;
      logic          v1_q;
      logic          clr1_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          prod_q <= '0;
          v1_q   <= 1'b0;
          clr1_q <= 1'b0;
        end else begin
          prod_q <= w_prod0;
          v1_q   <= v0_q;
          clr1_q <= clr0_q;
        end
      end

      assign w_acc_prod  = prod_q;
      assign w_acc_valid = v1_q;
      assign w_acc_clr   = clr1_q;
    end else begin : g_nopipe
      assign w_acc_prod  = w_prod0;
      assign w_acc_valid = v0_q;
      assign w_acc_clr   = clr0_q;
    end
  endgenerate

  // Accumulate stage: one guard bit above the accumulator exposes overflow.
  logic [ACC_WIDTH-1:0] f_q, f_d;
  logic                 vo_q, vo_d;
  logic                 ov_q, ov_d;
  logic [ACC_WIDTH:0]   w_prod_ext;
  logic [ACC_WIDTH:0]   w_base;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_ovf;

  assign w_prod_ext = {{EXT{w_acc_prod[PW-1]}}, w_acc_prod};
  assign w_base     = w_acc_clr ? '0 : {f_q[ACC_WIDTH-1], f_q};
  assign w_sum      = w_base + w_prod_ext;
  assign w_ovf      = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

  always_comb begin
    f_d  = f_q;
    vo_d = 1'b0;
    ov_d = 1'b0;
    if (w_acc_valid) begin
      vo_d = 1'b1;
      ov_d = w_ovf;
      if (w_ovf && (SAT != 0)) begin
        f_d = w_sum[ACC_WIDTH] ? C_MIN : C_MAX;
      end else begin
        f_d = w_sum[ACC_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_q  <= '0;
      vo_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      f_q  <= f_d;
      vo_q <= vo_d;
      ov_q <= ov_d;
    end
  end

  assign f         = f_q;
  assign valid_out = vo_q;
  assign overflow  = ov_q;

endmodule
`default_nettype wire

// File: tb/tb_mac_pipe_sat.sv
`default_nettype none
// ============================================================================
// Module   : tb_mac_pipe_sat
// Purpose  : Self-checking bench driving four MAC variants (PIPE 0/1 x SAT 1/0)
//            with one shared directed stimulus stream.
// Revision : 1.0
// ============================================================================
module tb_mac_pipe_sat;

  logic              clk;
  logic              reset;
  logic signed [7:0] a;
  logic signed [7:0] b;
  logic              valid_in;
  logic              clear_acc;

  logic signed [15:0] f_w  [4];
  logic               vo_w [4];
  logic               ov_w [4];

  // Instance i: PIPE = i%2, SAT = (i<2)
  generate
    for (genvar g = 0; g < 4; g++) begin : g_dut
      mac_pipe_sat #(
        .WIDTH(8), .ACC_WIDTH(16), .PIPE(g % 2), .SAT((g < 2) ? 1 : 0)
      ) u_dut (
        .clk(clk), .reset(reset), .a(a), .b(b),
        .valid_in(valid_in), .clear_acc(clear_acc),
        .valid_out(vo_w[g]), .f(f_w[g]), .overflow(ov_w[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Behavioural model: history of what was sampled at each edge; a beat
  // sampled at edge s lands in the accumulator at edge s+1+PIPE unless a
  // reset edge intervenes.
  int ecount = 0;
  bit hv [4096];
  bit hc [4096];
  bit hr [4096];
  int ha [4096];
  int hb [4096];
  int mf [4];
  bit mv [4];
  bit mo [4];
  bit model_ok = 0;

  function automatic bit fires(input int p);
    int s = ecount - 1 - p;
    if (s < 0) return 1'b0;
    if (!hv[s] || hr[s]) return 1'b0;
    for (int j = s + 1; j < ecount; j++) if (hr[j]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int raw_sum(input int p, input int fprev);
    int s = ecount - 1 - p;
    return (hc[s] ? 0 : fprev) + ha[s] * hb[s];
  endfunction

  function automatic bit ovf_of(input int sum);
    return (sum > 32767) || (sum < -32768);
  endfunction

  function automatic int resolve(input int sum, input bit sat);
    logic signed [15:0] t;
    if (!ovf_of(sum)) return sum;
    if (sat) return (sum > 0) ? 32767 : -32768;
    t = sum[15:0];
    return int'(t);
  endfunction

  always @(posedge clk) begin
    hv[ecount] <= valid_in;
    hc[ecount] <= clear_acc;
    hr[ecount] <= reset;
    ha[ecount] <= int'(a);
    hb[ecount] <= int'(b);
    ecount     <= ecount + 1;
    if (reset) model_ok <= 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (reset) begin
        mf[i] <= 0; mv[i] <= 1'b0; mo[i] <= 1'b0;
      end else if (fires(i % 2)) begin
        mf[i] <= resolve(raw_sum(i % 2, mf[i]), i < 2);
        mv[i] <= 1'b1;
        mo[i] <= ovf_of(raw_sum(i % 2, mf[i]));
      end else begin
        mv[i] <= 1'b0; mo[i] <= 1'b0;
      end
    end
  end

  typedef struct {
    int inst;
    int fv;
    bit ov;
  } ent_t;
  ent_t log_q[$];

  // Cycle compare against the model, plus a log of every output pulse.
  always @(negedge clk) begin
    if (model_ok) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("cyc f[%0d] edge%0d", i, ecount), int'(f_w[i]), mf[i]);
        check($sformatf("cyc valid_out[%0d] edge%0d", i, ecount), int'(vo_w[i]), int'(mv[i]));
        check($sformatf("cyc overflow[%0d] edge%0d", i, ecount), int'(ov_w[i]), int'(mo[i]));
        if (vo_w[i]) log_q.push_back('{inst: i, fv: int'(f_w[i]), ov: ov_w[i]});
      end
    end
  end

  // Compare the logged pulses of instance i with hand-computed literals.
  task automatic check_log(input string tag, input int i, input int n,
                           input int e0, input int e1, input int e2, input int e3,
                           input int opos);
    int ef[4];
    int cnt;
    ef  = '{e0, e1, e2, e3};
    cnt = 0;
    foreach (log_q[k]) begin
      if (log_q[k].inst == i) begin
        if (cnt < n && cnt < 4) begin
          check($sformatf("%s[%0d] pulse%0d f", tag, i, cnt), log_q[k].fv, ef[cnt]);
          check($sformatf("%s[%0d] pulse%0d ovf", tag, i, cnt), int'(log_q[k].ov),
                (cnt == opos) ? 1 : 0);
        end
        cnt++;
      end
    end
    check($sformatf("%s[%0d] pulse count", tag, i), cnt, n);
  endtask

  // Settled value: pins both the DUT and the model to a literal.
  task automatic settle(input string tag, input int i, input int lit);
    check($sformatf("%s[%0d] dut f", tag, i), int'(f_w[i]), lit);
    check($sformatf("%s[%0d] model f", tag, i), mf[i], lit);
  endtask

  task automatic beat(input int av, input int bv, input bit c);
    @(negedge clk);
    a         = 8'(av);
    b         = 8'(bv);
    valid_in  = 1'b1;
    clear_acc = c;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in  = 1'b0;
      clear_acc = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; a = '0; b = '0; valid_in = 1'b0; clear_acc = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    idle(2);
    for (int i = 0; i < 4; i++) begin
      settle("reset", i, 0);
      check($sformatf("reset valid_out[%0d]", i), int'(vo_w[i]), 0);
      check($sformatf("reset overflow[%0d]", i), int'(ov_w[i]), 0);
    end

    log_q.delete();
    beat(3, 4, 1); beat(-2, 5, 0); beat(7, -1, 0); idle(4);
    for (int i = 0; i < 4; i++) check_log("stream", i, 3, 12, 2, -5, 0, -1);

    log_q.delete();
    beat(3, 4, 1); idle(2); beat(2, 2, 0); idle(4);
    for (int i = 0; i < 4; i++) check_log("bubble", i, 2, 12, 16, 0, 0, -1);

    log_q.delete();
    beat(127, 127, 1); beat(127, 127, 0); beat(127, 127, 0); beat(-1, 1, 0); idle(4);
    for (int i = 0; i < 4; i++) begin
      if (i < 2) check_log("satpos", i, 4, 16129, 32258, 32767, 32766, 2);
      else       check_log("wrappos", i, 4, 16129, 32258, -17149, -17150, 2);
    end

    log_q.delete();
    beat(-128, 127, 1); beat(-128, 127, 0); beat(-128, 127, 0); beat(1, 1, 0); idle(4);
    for (int i = 0; i < 4; i++) begin
      if (i < 2) check_log("satneg", i, 4, -16256, -32512, -32768, -32767, 2);
      else       check_log("wrapneg", i, 4, -16256, -32512, 16768, 16769, 2);
    end

    log_q.delete();
    beat(-128, -128, 1); beat(-128, -128, 0); idle(4);
    for (int i = 0; i < 4; i++)
      check_log("extreme", i, 2, 16384, (i < 2) ? 32767 : -32768, 0, 0, 1);

    log_q.delete();
    beat(10, 10, 1); beat(10, 10, 0); beat(-1, 3, 1); idle(4);
    for (int i = 0; i < 4; i++) check_log("midclr", i, 3, 100, 200, -3, 0, -1);

    log_q.delete();
    @(negedge clk); a = 8'sd9; b = 8'sd9; valid_in = 1'b0; clear_acc = 1'b1;
    @(negedge clk);
    idle(4);
    for (int i = 0; i < 4; i++) begin
      check_log("clrnovalid", i, 0, 0, 0, 0, 0, -1);
      settle("clrnovalid", i, -3);
    end

    log_q.delete();
    @(negedge clk); a = 8'sd1; b = 8'sd1; valid_in = 1'b1; clear_acc = 1'b0;
    @(negedge clk); a = 8'sd2; b = 8'sd2; valid_in = 1'b1; reset = 1'b1;
    @(negedge clk); reset = 1'b0; a = 8'sd5; b = 8'sd5; valid_in = 1'b1; clear_acc = 1'b0;
    idle(5);
    for (int i = 0; i < 4; i++) begin
      check_log("midreset", i, 1, 25, 0, 0, 0, -1);
      settle("midreset", i, 25);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mac_pipe_sat.md
Name: mac_pipe_sat

Overview:
Parametrised signed multiply-accumulate unit. It is the successor to the fixed 8x8/16-bit MAC. It adds:
- configurable operand and accumulator widths;
- an optional multiplier pipeline stage;
- a per-beat accumulator clear;
- selectable saturating or wrapping accumulation, with an overflow flag.

It sits in the datapath as a streaming dot-product engine fed by a valid-qualified operand stream.

Parameters:
- WIDTH, 8: signed operand width of a and b.
- ACC_WIDTH, 16: signed accumulator/result width. Must be >= 2*WIDTH; elaboration error otherwise.
- PIPE, 0: 0 = product feeds the accumulator combinationally; 1 = product is registered (one extra cycle of latency).
- SAT, 1: 1 = saturate on accumulator overflow; 0 = two's-complement wrap.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- a  input  WIDTH  signed operand A
- b  input  WIDTH  signed operand B
- valid_in  input  1  a/b/clear_acc carry a valid beat this cycle
- clear_acc  input  1  this beat restarts the accumulation (f = a*b instead of f + a*b)
- valid_out  output  1  f/overflow updated by a beat this cycle
- f  output  ACC_WIDTH  signed accumulator value
- overflow  output  1  the update reported by valid_out overflowed

Behaviour:
Reset:
- One clock, synchronous, active-high reset; all state is updated on the rising edge of clk.
- While reset=1 at an edge, every register clears: input regs, pipe reg, valid bits, f=0, valid_out=0, overflow=0.
- Beats in flight are discarded; nothing they carried ever produces valid_out.

Stage 0 (input register):
- a, b, valid_in and clear_acc are registered at every edge, unconditionally.

Stage 1 (PIPE=1 only):
- The product of the stage-0 regs (2*WIDTH bits, signed) is registered together with its valid and clear bits.

Accumulate stage:
- Fires when the valid bit arriving from the previous stage is 1.
- The product is sign-extended to ACC_WIDTH+1 bits.
- Sum = (clear ? 0 : f) + product, computed at ACC_WIDTH+1 bits.
- Overflow = the top two bits of the sum differ.
- If overflow and SAT=1: f <= +2^(ACC_WIDTH-1)-1 when the sum is positive, -2^(ACC_WIDTH-1) when negative.
- If overflow and SAT=0: f <= sum truncated to ACC_WIDTH bits.
- Otherwise f <= sum.
- valid_out <= 1 and overflow <= the overflow condition, at the same edge.
- If the incoming valid bit is 0: f holds, valid_out <= 0, overflow <= 0.

Latency:
- A beat presented with valid_in=1 before edge k is sampled at edge k.
- Its result appears at f/valid_out after edge k+1+PIPE.
- valid_out is a one-cycle pulse per beat.

Throughput and boundary conditions:
- One beat per cycle; back-to-back beats accumulate in order; no backpressure.
- Bubbles (valid_in=0) are allowed anywhere; f is held across them.
- clear_acc with valid_in=0 has no effect (it is qualified by valid).
- clear_acc on consecutive beats: each result is that beat's product alone.
- Saturation is evaluated per beat against the current f. From a saturated f, a product of opposite sign moves f back off the rail normally (no sticky state).
- overflow is never asserted when valid_out=0.
- Extreme product -2^(WIDTH-1) * -2^(WIDTH-1) = +2^(2*WIDTH-2). It fits in 2*WIDTH signed bits; no special case is needed.
- Deasserting reset makes the block accept a beat at the very next edge.

Test Plan:
All scenarios use WIDTH=8 and ACC_WIDTH=16; each is run with PIPE=0 and PIPE=1 unless noted.
1. Reset behaviour: hold reset 3 cycles, then release with valid_in=0 -> f=0, valid_out=0, overflow=0 at every check.
2. Streaming sequence: beats (3,4,clr=1), (-2,5), (7,-1) -> f = 12, 2, -5 on three consecutive valid_out pulses. First pulse appears after edge k+1 (PIPE=0) or k+2 (PIPE=1).
3. Bubbles: beat (3,4,clr=1), two idle cycles, then beat (2,2) -> valid_out pulses once, f holds 12 through the idle cycles, then f=16.
4. Saturation, SAT=1:
   - Three beats (127,127), first with clr=1 -> f = 16129, 32258, then 32767 with overflow=1 on the third pulse only.
   - Three beats (-128,127) -> f = -16256, -32512, then -32768 with overflow=1.
   - Repeat the positive case with SAT=0 -> third f = -17149, overflow=1.
5. Mid-stream clear: beats (10,10,clr=1), (10,10), (-1,3,clr=1) -> f = 100, 200, -3. Separately, clear_acc=1 with valid_in=0 -> no pulse and f unchanged.
6. Reset mid-operation: issue two back-to-back beats, assert reset for one cycle while they are in flight, then release -> no valid_out pulses from those beats; f=0. A new beat (5,5) with clr=0 afterwards gives f=25.
